// File: rtl/obw_meas_ctrl.sv
// obw_meas_ctrl: sequencer for one occupied-bandwidth measurement.
// Accepts a request, runs the left-edge finder, then the right-edge finder.
// It captures both edge bins and presents bandwidth and status on a valid/ready result port.
// Optional feature macro: OBW_TIMEOUT_EN bounds each finder wait to TIMEOUT_CYCLES.
// When the wait expires, the result is reported as a timeout (err=11).
module obw_meas_ctrl #(
  parameter int unsigned FREQ_BIN_WIDTH = 9,
  parameter int unsigned ACCUM_WIDTH    = 16,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic                      abort_i,
  output logic                      l_start_o,
  input  logic                      l_valid_i,
  input  logic [FREQ_BIN_WIDTH-1:0] l_f1_i,
  input  logic [FREQ_BIN_WIDTH-1:0] l_f2_i,
  input  logic [ACCUM_WIDTH-1:0]    l_L2_i,
  output logic                      r_start_o,
  input  logic                      r_valid_i,
  input  logic [FREQ_BIN_WIDTH-1:0] r_f1_i,
  input  logic [FREQ_BIN_WIDTH-1:0] r_f2_i,
  input  logic [ACCUM_WIDTH-1:0]    r_L1_i,
  output logic                      res_valid_o,
  input  logic                      res_ready_i,
  output logic [FREQ_BIN_WIDTH-1:0] res_f_left_o,
  output logic [FREQ_BIN_WIDTH-1:0] res_f_right_o,
  output logic [FREQ_BIN_WIDTH:0]   res_bw_o,
  output logic [1:0]                res_err_o,
  output logic                      busy_o
);

  localparam int unsigned BW_W = FREQ_BIN_WIDTH + 1;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_NOT_FND  = 2'b01;
  localparam logic [1:0] ERR_INVERTED = 2'b10;
`ifdef OBW_TIMEOUT_EN
  localparam logic [1:0] ERR_TIMEOUT  = 2'b11;
`endif

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START_L = 3'd1,
    WAIT_L  = 3'd2,
    START_R = 3'd3,
    WAIT_R  = 3'd4,
    CALC    = 3'd5,
    HOLD    = 3'd6
  } state_t;

  state_t state;

  logic [FREQ_BIN_WIDTH-1:0] l_f1_q, l_f2_q, r_f1_q, r_f2_q;
  logic [ACCUM_WIDTH-1:0]    l_L2_q, r_L1_q;

  logic            l_not_found, r_not_found, edges_inverted;
  logic [BW_W-1:0] calc_bw;
  logic            unused_ok;

  // Result evaluation from the captured crossings (a finder with no crossing reports f1==f2==0)
  assign l_not_found    = (l_f1_q == '0) && (l_f2_q == '0);
  assign r_not_found    = (r_f1_q == '0) && (r_f2_q == '0);
  assign edges_inverted = r_f1_q < l_f2_q;
  assign calc_bw        = BW_W'(r_f1_q) - BW_W'(l_f2_q) + BW_W'(1);

`ifdef OBW_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt;
  logic             wait_expired;

  // Last permitted wait cycle: this is the TIMEOUT_CYCLES-th cycle spent in the wait state
  assign wait_expired = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Edge powers are captured for observability only; bandwidth uses bins alone
  assign unused_ok = ^{l_L2_q, r_L1_q};
`else
  // Edge powers are captured for observability only; timeout depth is inert in this build
  assign unused_ok = ^{l_L2_q, r_L1_q, 32'(TIMEOUT_CYCLES)};
`endif

  // Measurement sequencer with registered handshake, start-pulse and result outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= IDLE;
      req_ready_o   <= 1'b1;
      busy_o        <= 1'b0;
      l_start_o     <= 1'b0;
      r_start_o     <= 1'b0;
      res_valid_o   <= 1'b0;
      res_f_left_o  <= '0;
      res_f_right_o <= '0;
      res_bw_o      <= '0;
      res_err_o     <= ERR_OK;
      l_f1_q        <= '0;
      l_f2_q        <= '0;
      l_L2_q        <= '0;
      r_f1_q        <= '0;
      r_f2_q        <= '0;
      r_L1_q        <= '0;
`ifdef OBW_TIMEOUT_EN
      wait_cnt      <= '0;
`endif
    end else begin
      l_start_o <= 1'b0;
      r_start_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_valid_i && req_ready_o) begin
            state       <= START_L;
            l_start_o   <= 1'b1;
            req_ready_o <= 1'b0;
            busy_o      <= 1'b1;
          end
        end
        START_L: begin
          if (abort_i) begin
            state       <= IDLE;
            req_ready_o <= 1'b1;
            busy_o      <= 1'b0;
          end else begin
            state <= WAIT_L;
`ifdef OBW_TIMEOUT_EN
            wait_cnt <= '0;
`endif
          end
        end
        WAIT_L: begin
          if (abort_i) begin
            state       <= IDLE;
            req_ready_o <= 1'b1;
            busy_o      <= 1'b0;
          end else if (l_valid_i) begin
            l_f1_q    <= l_f1_i;
            l_f2_q    <= l_f2_i;
            l_L2_q    <= l_L2_i;
            state     <= START_R;
            r_start_o <= 1'b1;
          end
`ifdef OBW_TIMEOUT_EN
          else if (wait_expired) begin
            state         <= HOLD;
            res_valid_o   <= 1'b1;
            res_err_o     <= ERR_TIMEOUT;
            res_bw_o      <= '0;
            res_f_left_o  <= '0;
            res_f_right_o <= '0;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
`endif
        end
        START_R: begin
          if (abort_i) begin
            state       <= IDLE;
            req_ready_o <= 1'b1;
            busy_o      <= 1'b0;
          end else begin
            state <= WAIT_R;
`ifdef OBW_TIMEOUT_EN
            wait_cnt <= '0;
`endif
          end
        end
        WAIT_R: begin
          if (abort_i) begin
            state       <= IDLE;
            req_ready_o <= 1'b1;
            busy_o      <= 1'b0;
          end else if (r_valid_i) begin
            r_f1_q <= r_f1_i;
            r_f2_q <= r_f2_i;
            r_L1_q <= r_L1_i;
            state  <= CALC;
          end
`ifdef OBW_TIMEOUT_EN
          else if (wait_expired) begin
            state         <= HOLD;
            res_valid_o   <= 1'b1;
            res_err_o     <= ERR_TIMEOUT;
            res_bw_o      <= '0;
            res_f_left_o  <= '0;
            res_f_right_o <= '0;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
`endif
        end
        CALC: begin
          if (abort_i) begin
            state       <= IDLE;
            req_ready_o <= 1'b1;
            busy_o      <= 1'b0;
          end else begin
            state         <= HOLD;
            res_valid_o   <= 1'b1;
            res_f_left_o  <= l_f2_q;
            res_f_right_o <= r_f1_q;
            if (l_not_found || r_not_found) begin
              res_err_o <= ERR_NOT_FND;
              res_bw_o  <= '0;
            end else if (edges_inverted) begin
              res_err_o <= ERR_INVERTED;
              res_bw_o  <= '0;
            end else begin
              res_err_o <= ERR_OK;
              res_bw_o  <= calc_bw;
            end
          end
        end
        HOLD: begin
          if (res_ready_i) begin
            state       <= IDLE;
            res_valid_o <= 1'b0;
            req_ready_o <= 1'b1;
            busy_o      <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          res_valid_o <= 1'b0;
          req_ready_o <= 1'b1;
          busy_o      <= 1'b0;
        end
      endcase
    end
  end

endmodule
